// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-bank writeback path.
package regfile_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 6;

    typedef struct packed {
        logic [LANES-1:0]             mask;
        logic [ADDR_W-1:0]            addr;
        logic [LANES-1:0][DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding writeback requests for one producer.
module wb_fifo #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter type         req_t      = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  req_t din,
    input  logic pop,
    output req_t head,
    output logic full,
    output logic empty
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    req_t            mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter between the ALU and LSU feeding register_bank's write port.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    src0_valid,
    output logic                    src0_ready,
    input  logic [LANES-1:0]        src0_mask,
    input  logic [ADDR_W-1:0]       src0_addr,
    input  logic [LANES*DATA_W-1:0] src0_data,
    input  logic                    src1_valid,
    output logic                    src1_ready,
    input  logic [LANES-1:0]        src1_mask,
    input  logic [ADDR_W-1:0]       src1_addr,
    input  logic [LANES*DATA_W-1:0] src1_data,
    output logic [LANES-1:0]        write_en,
    output logic [ADDR_W-1:0]       waddr,
    output logic [DATA_W-1:0]       wdata_0,
    output logic [DATA_W-1:0]       wdata_1,
    output logic [DATA_W-1:0]       wdata_2,
    output logic [DATA_W-1:0]       wdata_3,
    output logic [DATA_W-1:0]       wdata_4,
    output logic [DATA_W-1:0]       wdata_5,
    output logic [DATA_W-1:0]       wdata_6,
    output logic [DATA_W-1:0]       wdata_7,
    output logic                    wb_done,
    output logic [ADDR_W-1:0]       wb_done_addr,
    output logic                    wb_done_src
);

    wb_req_t req0, req1, head0, head1, head_sel;
    logic    full0, full1, empty0, empty1;
    logic    push0, push1, gnt0, gnt1;
    wb_src_e ptr_q, ptr_d;

    logic [LANES-1:0]             write_en_q;
    logic [ADDR_W-1:0]            waddr_q, wb_done_addr_q;
    logic [LANES-1:0][DATA_W-1:0] wdata_q;
    logic                         wb_done_q;
    wb_src_e                      wb_done_src_q;

    assign src0_ready = rst_n && !full0;
    assign src1_ready = rst_n && !full1;

    // Zero-mask requests are acknowledged but never stored.
    assign push0 = src0_valid && src0_ready && (|src0_mask);
    assign push1 = src1_valid && src1_ready && (|src1_mask);

    assign req0 = '{mask: src0_mask, addr: src0_addr, data: src0_data};
    assign req1 = '{mask: src1_mask, addr: src1_addr, data: src1_data};

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .req_t(wb_req_t)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .din   (req0),
        .pop   (gnt0),
        .head  (head0),
        .full  (full0),
        .empty (empty0)
    );

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .req_t(wb_req_t)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .din   (req1),
        .pop   (gnt1),
        .head  (head1),
        .full  (full1),
        .empty (empty1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= WB_SRC_ALU;
        else        ptr_q <= ptr_d;
    end

    // After any grant the pointer favours the source that was not served.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt0)      ptr_d = WB_SRC_LSU;
        else if (gnt1) ptr_d = WB_SRC_ALU;
    end

    always_comb begin
        gnt0     = !empty0 && (empty1 || (ptr_q == WB_SRC_ALU));
        gnt1     = !empty1 && (empty0 || (ptr_q == WB_SRC_LSU));
        head_sel = gnt1 ? head1 : head0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_en_q     <= '0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            wb_done_q      <= 1'b0;
            wb_done_addr_q <= '0;
            wb_done_src_q  <= WB_SRC_ALU;
        end else begin
            wb_done_q <= gnt0 || gnt1;
            if (gnt0 || gnt1) begin
                write_en_q     <= head_sel.mask;
                waddr_q        <= head_sel.addr;
                wdata_q        <= head_sel.data;
                wb_done_addr_q <= head_sel.addr;
                wb_done_src_q  <= gnt1 ? WB_SRC_LSU : WB_SRC_ALU;
            end else begin
                write_en_q <= '0;
            end
        end
    end

    assign write_en     = write_en_q;
    assign waddr        = waddr_q;
    assign wdata_0      = wdata_q[0];
    assign wdata_1      = wdata_q[1];
    assign wdata_2      = wdata_q[2];
    assign wdata_3      = wdata_q[3];
    assign wdata_4      = wdata_q[4];
    assign wdata_5      = wdata_q[5];
    assign wdata_6      = wdata_q[6];
    assign wdata_7      = wdata_q[7];
    assign wb_done      = wb_done_q;
    assign wb_done_addr = wb_done_addr_q;
    assign wb_done_src  = wb_done_src_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised self-checking bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int D = 2;

    typedef struct {
        logic [7:0]   mask;
        logic [5:0]   addr;
        logic [511:0] data;
    } item_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s0_valid = 1'b0, s1_valid = 1'b0;
    logic [7:0]   s0_mask = '0, s1_mask = '0;
    logic [5:0]   s0_addr = '0, s1_addr = '0;
    logic [511:0] s0_data = '0, s1_data = '0;
    logic         s0_ready, s1_ready;
    logic [7:0]   write_en;
    logic [5:0]   waddr, wb_done_addr;
    logic [63:0]  wd0, wd1, wd2, wd3, wd4, wd5, wd6, wd7;
    logic         wb_done, wb_done_src;
    logic [511:0] wdata_all;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state
    item_t        q0[$], q1[$];
    int           rr = 0;
    logic [7:0]   e_we = '0;
    logic [5:0]   e_waddr = '0, e_daddr = '0;
    logic [511:0] e_wdata = '0;
    logic         e_done = 1'b0, e_dsrc = 1'b0;
    logic         acc0 = 1'b0, acc1 = 1'b0;
    logic [63:0]  bank     [64][8];
    logic [63:0]  exp_bank [64][8];

    int obs_src[$];
    int obs_cyc[$];

    regfile_wb_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src0_valid   (s0_valid),
        .src0_ready   (s0_ready),
        .src0_mask    (s0_mask),
        .src0_addr    (s0_addr),
        .src0_data    (s0_data),
        .src1_valid   (s1_valid),
        .src1_ready   (s1_ready),
        .src1_mask    (s1_mask),
        .src1_addr    (s1_addr),
        .src1_data    (s1_data),
        .write_en     (write_en),
        .waddr        (waddr),
        .wdata_0      (wd0),
        .wdata_1      (wd1),
        .wdata_2      (wd2),
        .wdata_3      (wd3),
        .wdata_4      (wd4),
        .wdata_5      (wd5),
        .wdata_6      (wd6),
        .wdata_7      (wd7),
        .wb_done      (wb_done),
        .wb_done_addr (wb_done_addr),
        .wb_done_src  (wb_done_src)
    );

    assign wdata_all = {wd7, wd6, wd5, wd4, wd3, wd2, wd1, wd0};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cycle, got, exp);
        end
    endtask

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Spec-level model: queues per source, round robin serves the other source after any grant.
    task automatic model_step();
        item_t it;
        int    g;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            rr      = 0;
            e_we    = '0;
            e_waddr = '0;
            e_wdata = '0;
            e_done  = 1'b0;
            e_daddr = '0;
            e_dsrc  = 1'b0;
            return;
        end
        acc0 = s0_valid && (q0.size() < D);
        acc1 = s1_valid && (q1.size() < D);
        g = -1;
        if (q0.size() > 0 && q1.size() > 0) g = rr;
        else if (q0.size() > 0)             g = 0;
        else if (q1.size() > 0)             g = 1;
        if (g >= 0) begin
            it      = (g == 0) ? q0.pop_front() : q1.pop_front();
            e_we    = it.mask;
            e_waddr = it.addr;
            e_wdata = it.data;
            e_done  = 1'b1;
            e_daddr = it.addr;
            e_dsrc  = (g == 1);
            rr      = 1 - g;
            for (int l = 0; l < 8; l++)
                if (it.mask[l]) exp_bank[it.addr][l] = it.data[64*l +: 64];
        end else begin
            e_we   = '0;
            e_done = 1'b0;
        end
        if (acc0 && s0_mask != 0) q0.push_back('{mask: s0_mask, addr: s0_addr, data: s0_data});
        if (acc1 && s1_mask != 0) q1.push_back('{mask: s1_mask, addr: s1_addr, data: s1_data});
    endtask

    task automatic compare_outputs();
        check("src0_ready", 512'(s0_ready), 512'(rst_n && q0.size() < D));
        check("src1_ready", 512'(s1_ready), 512'(rst_n && q1.size() < D));
        check("write_en", 512'(write_en), 512'(e_we));
        check("wb_done", 512'(wb_done), 512'(e_done));
        check("waddr", 512'(waddr), 512'(e_waddr));
        check("wdata", wdata_all, e_wdata);
        if (e_done) begin
            check("wb_done_addr", 512'(wb_done_addr), 512'(e_daddr));
            check("wb_done_src", 512'(wb_done_src), 512'(e_dsrc));
        end
        if (wb_done === 1'b1) begin
            obs_src.push_back(int'(wb_done_src));
            obs_cyc.push_back(cycle);
        end
        for (int l = 0; l < 8; l++)
            if (write_en[l] === 1'b1) bank[waddr][l] = wdata_all[64*l +: 64];
    endtask

    // Inputs have been driven; run one edge through model and DUT, then check.
    task automatic tick();
        @(posedge clk);
        model_step();
        cycle++;
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle_inputs();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
    endtask

    task automatic compare_bank(input string tag);
        for (int a = 0; a < 64; a++)
            for (int l = 0; l < 8; l++)
                if (bank[a][l] !== exp_bank[a][l]) check(tag, 512'(bank[a][l]), 512'(exp_bank[a][l]));
        check({tag, "_sweep"}, 512'(1), 512'(1 == 1 && bank[63][7] === exp_bank[63][7]));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        idle_inputs();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int i0, i1, budget, first;
        for (int a = 0; a < 64; a++)
            for (int l = 0; l < 8; l++) begin
                bank[a][l]     = '0;
                exp_bank[a][l] = '0;
            end

        // Reset with noisy valids: nothing accepted, outputs cleared.
        rst_n    = 1'b0;
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        s0_mask  = 8'hFF;
        s1_mask  = 8'hFF;
        repeat (2) tick();
        check("reset_write_en", 512'(write_en), 512'(8'h00));
        idle_inputs();
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 512'({s0_ready, s1_ready}), 512'(2'b11));

        // Single ALU write: visible after E+1, one-cycle done pulse.
        s0_valid = 1'b1;
        s0_mask  = 8'hFF;
        s0_addr  = 6'h05;
        s0_data  = rand_data();
        tick();
        idle_inputs();
        check("single_not_yet", 512'(wb_done), 512'(0));
        tick();
        check("single_we", 512'(write_en), 512'(8'hFF));
        check("single_addr", 512'(waddr), 512'(6'h05));
        check("single_src", 512'(wb_done_src), 512'(0));
        tick();
        check("single_pulse_end", 512'(wb_done), 512'(0));
        check("bank_addr5_lane0", 512'(bank[5][0]), 512'(s0_data[63:0]));

        // Contention from a fresh reset: strict alternation starting with src0.
        do_reset(1);
        obs_src.delete();
        obs_cyc.delete();
        i0 = 0;
        i1 = 0;
        budget = 0;
        while ((i0 < 6 || i1 < 6 || q0.size() > 0 || q1.size() > 0 || e_done) && budget < 40) begin
            s0_valid = (i0 < 6);
            s0_mask  = 8'hFF;
            s0_addr  = 6'(i0);
            s0_data  = rand_data();
            s1_valid = (i1 < 6);
            s1_mask  = 8'hFF;
            s1_addr  = 6'(32 + i1);
            s1_data  = rand_data();
            tick();
            if (acc0) i0++;
            if (acc1) i1++;
            budget++;
        end
        idle_inputs();
        check("contention_budget", 512'(budget < 40), 512'(1));
        check("contention_writes", 512'(obs_src.size()), 512'(12));
        if (obs_src.size() == 12) begin
            for (int k = 0; k < 12; k++) check("contention_order", 512'(obs_src[k]), 512'(k % 2));
            first = obs_cyc[0];
            check("contention_back_to_back", 512'(obs_cyc[11] - first), 512'(11));
        end
        compare_bank("bank_contention");

        // Zero mask is swallowed; partial mask writes only selected lanes.
        s0_valid = 1'b1;
        s0_mask  = 8'h00;
        s0_addr  = 6'h07;
        s0_data  = rand_data();
        tick();
        idle_inputs();
        repeat (2) tick();
        check("zero_mask_done", 512'(wb_done), 512'(0));
        s1_valid = 1'b1;
        s1_mask  = 8'hA5;
        s1_addr  = 6'h3F;
        s1_data  = rand_data();
        tick();
        idle_inputs();
        tick();
        check("partial_we", 512'(write_en), 512'(8'hA5));
        check("partial_src", 512'(wb_done_src), 512'(1));
        tick();
        check("partial_lane1_kept", 512'(bank[63][1]), 512'(64'd0));
        check("partial_lane7_written", 512'(bank[63][7]), 512'(s1_data[511:448]));

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst_n    = ($urandom_range(0, 60) != 0);
            s0_valid = $urandom_range(0, 1);
            s1_valid = $urandom_range(0, 1);
            s0_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            s1_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            s0_addr  = 6'($urandom);
            s1_addr  = 6'($urandom);
            s0_data  = rand_data();
            s1_data  = rand_data();
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        repeat (6) tick();
        compare_bank("bank_random");

        // Reset mid-stream: queued requests vanish without writes.
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        s0_mask  = 8'hFF;
        s1_mask  = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            s0_addr = 6'(10 + k);
            s1_addr = 6'(20 + k);
            s0_data = rand_data();
            s1_data = rand_data();
            tick();
        end
        do_reset(1);
        obs_src.delete();
        repeat (5) tick();
        check("midreset_no_writes", 512'(obs_src.size()), 512'(0));
        check("midreset_write_en", 512'(write_en), 512'(8'h00));
        compare_bank("bank_midreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
